// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-size encoding
// (identical to the datapath's dataSize) and the responder state encoding.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Big-endian lane steering for one memory word: byte enables, lane-aligned
// store data, right-justified zero-extended load data and a misalign flag.
module dmem_lane_ctrl
  import dmem_pkg::*;
(
  input  logic [1:0]  byteOff,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] rawWord,
  output logic [3:0]  byteEn,
  output logic [31:0] laneWdata,
  output logic [31:0] rdata,
  output logic        badAccess
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    byteEn    = 4'b0000;
    laneWdata = '0;
    rdata     = '0;
    badAccess = 1'b0;
    case (size)
      SIZE_BYTE: begin
        // offset 0 is the most significant lane
        byteEn    = 4'b1000 >> byteOff;
        laneWdata = {4{wdata[7:0]}};
        rdata     = {24'h0, rawWord[{~byteOff, 3'b000} +: 8]};
      end
      SIZE_HALF: begin
        byteEn    = byteOff[1] ? 4'b0011 : 4'b1100;
        laneWdata = {2{wdata[15:0]}};
        rdata     = {16'h0, (byteOff[1] ? rawWord[15:0] : rawWord[31:16])};
        badAccess = byteOff[0];
      end
      SIZE_WORD: begin
        byteEn    = 4'b1111;
        laneWdata = wdata;
        rdata     = rawWord;
        badAccess = |byteOff;
      end
      default: badAccess = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the data-memory port: one request at a time, WAIT_CYCLES
// wait states, then a byte/half/word access and a one-cycle response pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t        state, nextState;
  logic [CW-1:0] waitCnt;
  logic [31:0]   addrQ, wdataQ;
  logic          wrQ;
  logic [1:0]    sizeQ;
  logic [31:0]   rdataQ;
  logic          errQ;
  logic [31:0]   mem [DEPTH];

  logic          accept, accessNow, useLive;
  logic [31:0]   accAddr, accWdata;
  logic          accWr;
  logic [1:0]    accSize;
  logic [AW-1:0] wordIdx;
  logic          outOfRange, badAccess, accErr;
  logic [3:0]    byteEn;
  logic [31:0]   laneWdata, laneRdata;

  // reset forces IDLE asynchronously, so no access can fire while it is held
  assign req_ready  = (state == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdataQ;
  assign resp_err   = errQ;

  // with zero wait states the access uses the request as it is being accepted
  assign useLive  = (state == IDLE);
  assign accAddr  = useLive ? req_addr  : addrQ;
  assign accWdata = useLive ? req_wdata : wdataQ;
  assign accWr    = useLive ? req_wr    : wrQ;
  assign accSize  = useLive ? req_size  : sizeQ;

  assign wordIdx    = accAddr[AW+1:2];
  assign outOfRange = accAddr[31:2] >= 30'(DEPTH);
  assign accErr     = badAccess || outOfRange;

  dmem_lane_ctrl u_lane_ctrl (
    .byteOff   (accAddr[1:0]),
    .size      (accSize),
    .wdata     (accWdata),
    .rawWord   (mem[wordIdx]),
    .byteEn    (byteEn),
    .laneWdata (laneWdata),
    .rdata     (laneRdata),
    .badAccess (badAccess)
  );

  always_comb begin
    nextState = state;
    accessNow = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            nextState = RESP;
            accessNow = 1'b1;
          end else begin
            nextState = WAIT;
          end
        end
      end
      WAIT: begin
        if (waitCnt == '0) begin
          nextState = RESP;
          accessNow = 1'b1;
        end
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addrQ   <= '0;
      wdataQ  <= '0;
      wrQ     <= 1'b0;
      sizeQ   <= SIZE_BYTE;
      waitCnt <= '0;
      rdataQ  <= '0;
      errQ    <= 1'b0;
    end else begin
      if (accept) begin
        addrQ   <= req_addr;
        wdataQ  <= req_wdata;
        wrQ     <= req_wr;
        sizeQ   <= req_size;
        waitCnt <= CW'(WAIT_CYCLES - 1);
      end else if (state == WAIT) begin
        waitCnt <= waitCnt - 1'b1;
      end

      if (accessNow) begin
        errQ   <= accErr;
        rdataQ <= (accErr || accWr) ? '0 : laneRdata;
      end else if (state == RESP) begin
        errQ   <= 1'b0;
        rdataQ <= '0;
      end
    end
  end

  // NOTE: the RAM array is deliberately not reset; its contents are undefined until written.
  always_ff @(posedge clk) begin
    if (accessNow && accWr && !accErr) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[wordIdx][8*i +: 8] <= laneWdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance for the main
// checks and a WAIT_CYCLES=0 instance for the zero-wait latency.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, reqValid0;
  logic [31:0] req_addr, req_wdata;
  logic        req_wr;
  logic [1:0]  req_size;

  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;
  logic        reqReady0, respValid0, respErr0, busy0;
  logic [31:0] respRdata0;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wr(req_wr), .req_size(req_size),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(reqValid0), .req_ready(reqReady0),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wr(req_wr), .req_size(req_size),
    .resp_valid(respValid0), .resp_rdata(respRdata0), .resp_err(respErr0), .busy(busy0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request (already in an idle cycle, #1 after an edge) and
  // watches 8 cycles for the response; lat=-1 means none, 99 means several.
  task automatic runReq(input int inst, input logic wr, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int pulses;
    logic v;
    pulses = 0;
    lat    = -1;
    rdata  = 32'hBAD0BAD0;
    err    = 1'b0;
    req_addr  = addr;
    req_wdata = wdata;
    req_wr    = wr;
    req_size  = sz;
    if (inst == 0) req_valid = 1'b1;
    else           reqValid0 = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reqValid0 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      v = (inst == 0) ? resp_valid : respValid0;
      if (v) begin
        pulses++;
        if (lat < 0) begin
          lat   = k;
          rdata = (inst == 0) ? resp_rdata : respRdata0;
          err   = (inst == 0) ? resp_err   : respErr0;
        end
      end
      @(posedge clk);
      #1;
    end
    if (pulses > 1) lat = 99;
  endtask

  task automatic req(input string tag, input int inst, input logic wr, input logic [1:0] sz,
                     input logic [31:0] addr, input logic [31:0] wdata, input bit chkData,
                     input logic [31:0] expData, input logic expErr, input int expLat);
    logic [31:0] rdata;
    logic        err;
    int          lat;
    runReq(inst, wr, sz, addr, wdata, rdata, err, lat);
    check({tag, ".lat"}, 32'(lat), 32'(expLat));
    check({tag, ".err"}, {31'h0, err}, {31'h0, expErr});
    if (chkData) check({tag, ".rdata"}, rdata, expData);
  endtask

  initial begin
    logic [9:0] readyMask, respMask, busyMask;
    logic       sawResp;

    reset     = 1'b1;
    req_valid = 1'b0;
    reqValid0 = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wr    = 1'b0;
    req_size  = SIZE_WORD;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst.ready",  {31'h0, req_ready},  32'h1);
    check("rst.busy",   {31'h0, busy},       32'h0);
    check("rst.rvalid", {31'h0, resp_valid}, 32'h0);
    check("rst.rdata",  resp_rdata,          32'h0);
    check("rst.err",    {31'h0, resp_err},   32'h0);
    @(posedge clk);
    #1;

    // word store/load round trip, latency 3
    req("st_w10", 0, 1, SIZE_WORD, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0, 3);
    req("ld_w10", 0, 0, SIZE_WORD, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0, 3);

    // byte store merges into the word; sub-word loads right-justify
    req("st_b11",  0, 1, SIZE_BYTE, 32'h11, 32'h000000AB, 1, 32'h0, 0, 3);
    req("ld_w10b", 0, 0, SIZE_WORD, 32'h10, 32'h0, 1, 32'hDEABBEEF, 0, 3);
    req("ld_h12",  0, 0, SIZE_HALF, 32'h12, 32'h0, 1, 32'h0000BEEF, 0, 3);
    req("ld_b11",  0, 0, SIZE_BYTE, 32'h11, 32'h0, 1, 32'h000000AB, 0, 3);
    req("ld_b13",  0, 0, SIZE_BYTE, 32'h13, 32'h0, 1, 32'h000000EF, 0, 3);
    req("ld_h10",  0, 0, SIZE_HALF, 32'h10, 32'h0, 1, 32'h0000DEAB, 0, 3);

    // lane enables preserve neighbours; upper store bits are ignored
    req("st_w30",  0, 1, SIZE_WORD, 32'h30, 32'h01020304, 1, 32'h0, 0, 3);
    req("st_h32",  0, 1, SIZE_HALF, 32'h32, 32'hFFFFAAAA, 1, 32'h0, 0, 3);
    req("ld_w30a", 0, 0, SIZE_WORD, 32'h30, 32'h0, 1, 32'h0102AAAA, 0, 3);
    req("st_b30",  0, 1, SIZE_BYTE, 32'h30, 32'h00123477, 1, 32'h0, 0, 3);
    req("ld_w30b", 0, 0, SIZE_WORD, 32'h30, 32'h0, 1, 32'h7702AAAA, 0, 3);

    // misaligned and illegal-size requests error out without writing
    req("st_w13", 0, 1, SIZE_WORD, 32'h13, 32'hFFFFFFFF, 1, 32'h0, 1, 3);
    req("st_h11", 0, 1, SIZE_HALF, 32'h11, 32'hFFFFFFFF, 1, 32'h0, 1, 3);
    req("st_s10", 0, 1, 2'b10,     32'h10, 32'hFFFFFFFF, 1, 32'h0, 1, 3);
    req("ld_s10", 0, 0, 2'b10,     32'h10, 32'h0,        1, 32'h0, 1, 3);
    req("ld_w10c", 0, 0, SIZE_WORD, 32'h10, 32'h0, 1, 32'hDEABBEEF, 0, 3);

    // range boundary; an out-of-range store must not alias onto word 4
    req("ld_1000", 0, 0, SIZE_WORD, 32'h1000, 32'h0, 1, 32'h0, 1, 3);
    req("ld_ffc",  0, 0, SIZE_WORD, 32'hFFC,  32'h0, 0, 32'h0, 0, 3);
    req("st_1010", 0, 1, SIZE_WORD, 32'h1010, 32'h55555555, 1, 32'h0, 1, 3);
    req("ld_w10d", 0, 0, SIZE_WORD, 32'h10, 32'h0, 1, 32'hDEABBEEF, 0, 3);

    // held request: one acceptance every 4 cycles
    readyMask = '0;
    respMask  = '0;
    busyMask  = '0;
    req_wr    = 1'b0;
    req_size  = SIZE_WORD;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_addr     = 32'h40 + 32'(4 * i);
      readyMask[i] = req_ready;
      respMask[i]  = resp_valid;
      busyMask[i]  = busy;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("hold.ready", {22'h0, readyMask}, 32'h111);
    check("hold.resp",  {22'h0, respMask},  32'h088);
    check("hold.busy",  {22'h0, busyMask},  32'h2EE);

    // reset during WAIT drops the store and the response
    req("st_w20", 0, 1, SIZE_WORD, 32'h20, 32'hCAFEF00D, 1, 32'h0, 0, 3);
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    req_wr    = 1'b1;
    req_size  = SIZE_WORD;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    check("mid.rvalid", {31'h0, resp_valid}, 32'h0);
    check("mid.rdata",  resp_rdata,          32'h0);
    check("mid.err",    {31'h0, resp_err},   32'h0);
    check("mid.busy",   {31'h0, busy},       32'h0);
    sawResp = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      sawResp |= resp_valid;
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      sawResp |= resp_valid;
    end
    check("mid.noresp", {31'h0, sawResp},   32'h0);
    check("mid.ready",  {31'h0, req_ready}, 32'h1);
    req("ld_w20", 0, 0, SIZE_WORD, 32'h20, 32'h0, 1, 32'hCAFEF00D, 0, 3);

    // zero wait states: response in the cycle after acceptance
    req("z.st_w40", 1, 1, SIZE_WORD, 32'h40, 32'h11223344, 1, 32'h0, 0, 1);
    req("z.ld_w40", 1, 0, SIZE_WORD, 32'h40, 32'h0, 1, 32'h11223344, 0, 1);
    req("z.st_b43", 1, 1, SIZE_BYTE, 32'h43, 32'h00000099, 1, 32'h0, 0, 1);
    req("z.ld_w40b", 1, 0, SIZE_WORD, 32'h40, 32'h0, 1, 32'h11223399, 0, 1);
    req("z.ld_h41", 1, 0, SIZE_HALF, 32'h41, 32'h0, 1, 32'h0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the datapath's data-memory port.
- Accepts one load/store request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states, then performs a byte-, half- or word-sized access on an internal word-organised RAM.
- Returns a single-cycle response pulse carrying read data or an error flag.
- Replaces the zero-latency dmem so the single-cycle core can be moved to a multi-cycle/stalling implementation.

Parameters:
DEPTH, 1024, number of 32-bit words in the RAM; must be a power of two.
WAIT_CYCLES, 2, wait states between request acceptance and access; 0 is legal.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  responder can accept a request this cycle
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
req_wr  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 11 word, 10 illegal (same encoding as dataSize)
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  load data, zero-extended, right-justified; 0 for stores and errors
resp_err  out  1  request was misaligned, illegal size or out of range
busy  out  1  request in flight (state != IDLE)

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0, req_ready = 1 once reset deasserts.
  - RAM contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - When req_valid = 1, latch addr, wdata, wr and size.
  - If WAIT_CYCLES > 0: load wait counter with WAIT_CYCLES-1 and go to WAIT.
  - If WAIT_CYCLES = 0: perform the access on this edge and go to RESP.
- WAIT:
  - req_ready = 0.
  - Counter decrements each cycle.
  - When the counter is 0: perform the access on that edge and go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle, with resp_rdata and resp_err registered.
  - req_ready = 0.
  - Next state is IDLE.
  - No response back-pressure.
- Latency: resp_valid is high in cycle N+WAIT_CYCLES+1, where N is the acceptance cycle. Throughput is one request per WAIT_CYCLES+2 cycles.
- Byte order is big-endian:
  - Word index = addr[log2(DEPTH)+1:2].
  - Byte offset 0 maps to bits [31:24], offset 3 to bits [7:0].
  - Half offset 0 maps to [31:16], offset 2 to [15:0].
- Store: only the addressed lanes are written (byte enables); other lanes are preserved.
- Load: addressed lanes are shifted to the LSBs and the upper bits zeroed. Sign extension stays in the datapath.
- Error conditions:
  - half with addr[0] = 1
  - word with addr[1:0] != 0
  - size 10
  - addr[31:2] >= DEPTH
- On error: no RAM write, resp_err = 1, resp_rdata = 0, same latency as a good access.
- A load issued after a completed store sees the stored data. No forwarding is required because requests never overlap.
- req_valid while req_ready = 0 is ignored. The requester holds the request until acceptance.
- Reset mid-operation: an in-flight request is dropped, no response is issued, and a store whose access edge has not yet occurred does not modify the RAM.

Decomposition:
- Shared package dmem_pkg:
  - size constants SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b11
  - state encoding IDLE/WAIT/RESP
- One combinational sub-module, dmem_lane_ctrl. From (addr[1:0], size, wdata, raw read word) it produces:
  - 4-bit byte enable
  - lane-aligned write word
  - right-justified read data
  - misalign/illegal flag
- Range check and FSM stay in dmem_responder.

Test Plan:
1. WAIT_CYCLES = 2. Store word 0xDEADBEEF at 0x10, accepted cycle 0 -> resp_valid only in cycle 3, err 0. Load word 0x10 -> rdata 0xDEADBEEF.
2. Store byte 0x000000AB at 0x11 -> load word 0x10 returns 0xDEABBEEF. Load half 0x12 returns 0x0000BEEF. Load byte 0x11 returns 0x000000AB.
3. Store word at 0x13, then half at 0x11, then size 10 at 0x10 -> each gives resp_err = 1, rdata 0, same latency. A subsequent load word 0x10 is unchanged.
4. DEPTH = 1024: load word at 0x1000 -> err 1. Load word at 0xFFC -> err 0.
5. Hold req_valid high for 10 cycles with different addresses -> exactly one request is accepted per 4 cycles, and req_ready is low in WAIT/RESP.
6. Store 0x12345678 at 0x20, assert reset in cycle 1 -> no resp_valid, all outputs 0, RAM word at 0x20 unchanged. Repeat with WAIT_CYCLES = 0 -> resp_valid in cycle 1.
